// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter: FSM states, port ids, command word.
// Consumed by mem_arbiter (optional address check via MEM_ARB_ADDR_CHECK_EN) and mem_arb_rr2.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        RESP
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEFAULT_DEPTH = 256;

    typedef struct packed {
        logic        write;
        logic [31:0] adr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin grant: on contention the port that did not win last time wins.
// The pointer resets to PORT1 so PORT0 wins the first contention.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] valid_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o = valid_i;
        if (valid_i == 2'b11) begin
            gnt_o = (last_q == PORT0) ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        last_d = last_q;
        if (en_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1] ? PORT1 : PORT0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer for a single-port synchronous-read data memory, 4-cycle accesses.
// Define MEM_ARB_ADDR_CHECK_EN to reject addresses >= DEPTH without touching the memory.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_write,
    input  logic [31:0] p0_req_adr,
    input  logic [31:0] p0_req_wdata,
    output logic        p0_resp_valid,
    input  logic        p0_resp_ready,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_write,
    input  logic [31:0] p1_req_adr,
    input  logic [31:0] p1_req_wdata,
    output logic        p1_resp_valid,
    input  logic        p1_resp_ready,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,

    output logic        mem_write,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

`ifdef MEM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    arb_state_e  state_q;
    mem_cmd_t    cmd_q;
    logic        mem_write_q;
    logic        owner_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] rdata_q;

    logic [1:0]  req_valid;
    logic [1:0]  gnt;
    logic        accept;
    logic        sel;
    logic        req_err;
    logic        owner_resp_ready;
    mem_cmd_t    req_cmd;

    assign req_valid = {p1_req_valid, p0_req_valid};
    // Gated by reset_n so req_ready is 0 throughout reset even with requests pending.
    assign accept    = reset_n && (state_q == IDLE) && (req_valid != 2'b00);

    mem_arb_rr2 u_rr2 (
        .clock   (clock),
        .reset_n (reset_n),
        .valid_i (req_valid),
        .en_i    (accept),
        .gnt_o   (gnt)
    );

    assign sel = gnt[1];

    always_comb begin
        req_cmd.write = p0_req_write;
        req_cmd.adr   = p0_req_adr;
        req_cmd.wdata = p0_req_wdata;
        if (sel) begin
            req_cmd.write = p1_req_write;
            req_cmd.adr   = p1_req_adr;
            req_cmd.wdata = p1_req_wdata;
        end
    end

    assign req_err          = ADDR_CHECK && (req_cmd.adr >= DEPTH_W);
    assign owner_resp_ready = (owner_q == PORT1) ? p1_resp_ready : p0_resp_ready;

    assign p0_req_ready = accept && gnt[0];
    assign p1_req_ready = accept && gnt[1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cmd_q        <= '0;
            mem_write_q  <= 1'b0;
            owner_q      <= PORT0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q <= sel;
                        if (req_err) begin
                            // Errored commands leave cmd_q (and thus the memory bus) untouched.
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            rdata_q      <= '0;
                            state_q      <= RESP;
                        end else begin
                            cmd_q       <= req_cmd;
                            mem_write_q <= req_cmd.write;
                            state_q     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    mem_write_q <= 1'b0;
                    state_q     <= CAPTURE;
                end
                CAPTURE: begin
                    rdata_q      <= cmd_q.write ? 32'h0 : mem_rd;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (owner_resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_write = mem_write_q;
    assign mem_adr   = cmd_q.adr;
    assign mem_wd    = cmd_q.wdata;

    assign p0_resp_valid = resp_valid_q && (owner_q == PORT0);
    assign p1_resp_valid = resp_valid_q && (owner_q == PORT1);
    assign p0_resp_err   = resp_valid_q && resp_err_q && (owner_q == PORT0);
    assign p1_resp_err   = resp_valid_q && resp_err_q && (owner_q == PORT1);
    assign p0_resp_rdata = (owner_q == PORT0) ? rdata_q : 32'h0;
    assign p1_resp_rdata = (owner_q == PORT1) ? rdata_q : 32'h0;

endmodule
